// File: rtl/qlf_dsp_pkg.sv
// -----------------------------------------------------------------------------
// qlf_dsp_pkg
// Shared definitions for the qlf_k6n10f DSP behavioural models.
//   - SHIFT_W / PIPE_STAGES_MAX / SAT_CALC_W : width and range limits
//   - mac_ctrl_t      : per-sample control bundle carried down the MAC pipeline
//   - mac_latency()   : edges from an accepted sample to its result
//   - min_acc_width() : smallest accumulator that holds one full product
//   - sat_max_val() / sat_min_val() : signed range limits for a given width
// -----------------------------------------------------------------------------
package qlf_dsp_pkg;

    localparam int SHIFT_W         = 6;
    localparam int PIPE_STAGES_MAX = 2;
    // Working width for saturation compares; any ACC_WIDTH+1 up to this fits.
    localparam int SAT_CALC_W      = 128;

    typedef struct packed {
        logic               valid;
        logic               acc_en;
        logic               acc_clr;
        logic [SHIFT_W-1:0] shift;
        logic               round;
        logic               saturate;
    } mac_ctrl_t;

    function automatic int mac_latency(input int register_inputs, input int pipe_stages);
        return register_inputs + pipe_stages + 2;
    endfunction

    function automatic int min_acc_width(input int a_width, input int b_width);
        return a_width + b_width + 1;
    endfunction

    // Largest signed value representable in w bits: 2^(w-1)-1.
    function automatic logic signed [SAT_CALC_W-1:0] sat_max_val(input int unsigned w);
        logic signed [SAT_CALC_W-1:0] v;
        v        = '0;
        v[w-1]   = 1'b1;
        return v - 1;
    endfunction

    // Smallest signed value representable in w bits: -2^(w-1).
    function automatic logic signed [SAT_CALC_W-1:0] sat_min_val(input int unsigned w);
        logic signed [SAT_CALC_W-1:0] v;
        v = '1;
        return v << (w - 1);
    endfunction

endpackage

// File: rtl/dsp_mac_round_sat.sv
// -----------------------------------------------------------------------------
// dsp_mac_round_sat
// Combinational output conditioning for the MAC: optional round half-up,
// arithmetic right shift, then saturate or truncate to OUT_WIDTH.
//   acc      in  ACC_WIDTH  signed accumulator value
//   shift    in  SHIFT_W    arithmetic right shift amount
//   round    in  1          add 2^(shift-1) before shifting (ignored for shift 0)
//   saturate in  1          clip to signed OUT_WIDTH range instead of truncating
//   z        out OUT_WIDTH  conditioned result
//   sat      out 1          result was clipped
// -----------------------------------------------------------------------------
module dsp_mac_round_sat
    import qlf_dsp_pkg::*;
#(
    parameter int ACC_WIDTH = 40,
    parameter int OUT_WIDTH = 38
) (
    input  logic signed [ACC_WIDTH-1:0] acc,
    input  logic        [SHIFT_W-1:0]   shift,
    input  logic                        round,
    input  logic                        saturate,
    output logic        [OUT_WIDTH-1:0] z,
    output logic                        sat
);

    localparam logic signed [SAT_CALC_W-1:0] Q_MAX = sat_max_val(OUT_WIDTH);
    localparam logic signed [SAT_CALC_W-1:0] Q_MIN = sat_min_val(OUT_WIDTH);

    logic        [ACC_WIDTH:0]    rnd_add;
    logic signed [ACC_WIDTH:0]    r;
    logic signed [ACC_WIDTH:0]    q;
    logic signed [SAT_CALC_W-1:0] q_w;

    // NOTE: every output of this block gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        rnd_add = '0;
        // A rounding bit beyond ACC_WIDTH+1 shifts out to zero, which keeps the
        // sum in ACC_WIDTH+1-bit modular arithmetic for very large shifts.
        if (round && shift != '0) begin
            rnd_add = {{ACC_WIDTH{1'b0}}, 1'b1} << (shift - 6'd1);
        end
        r   = (ACC_WIDTH+1)'(acc) + $signed(rnd_add);
        q   = r >>> shift;
        q_w = SAT_CALC_W'(q);
        z   = q[OUT_WIDTH-1:0];
        sat = 1'b0;
        if (saturate) begin
            if (q_w > Q_MAX) begin
                z   = Q_MAX[OUT_WIDTH-1:0];
                sat = 1'b1;
            end else if (q_w < Q_MIN) begin
                z   = Q_MIN[OUT_WIDTH-1:0];
                sat = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dsp_mac_pipe.sv
// -----------------------------------------------------------------------------
// dsp_mac_pipe
// Pipelined signed/unsigned multiply-accumulate with rounding shift and
// optional saturation. Latency REGISTER_INPUTS + PIPE_STAGES + 2, one sample
// per clock, no backpressure.
//   clock_i        in  1          rising-edge clock
//   reset_i        in  1          asynchronous active-high reset
//   valid_i        in  1          sample qualifier
//   a_i / b_i      in  A/B_WIDTH  operands
//   unsigned_a_i/b in  1          operand is unsigned
//   acc_en_i       in  1          add product to running accumulator
//   acc_clr_i      in  1          restart accumulator with this product
//   shift_right_i  in  6          arithmetic right shift at output
//   round_i        in  1          round half-up before the shift
//   saturate_i     in  1          clip to signed OUT_WIDTH range
//   valid_o        out 1          z_o carries a new result
//   z_o            out OUT_WIDTH  result
//   overflow_o     out 1          sticky accumulator overflow
//   sat_o          out 1          this result was clipped
// -----------------------------------------------------------------------------
module dsp_mac_pipe
    import qlf_dsp_pkg::*;
#(
    parameter int A_WIDTH         = 20,
    parameter int B_WIDTH         = 18,
    parameter int ACC_WIDTH       = 40,
    parameter int OUT_WIDTH       = 38,
    parameter int REGISTER_INPUTS = 1,
    parameter int PIPE_STAGES     = 0
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 valid_i,
    input  logic [A_WIDTH-1:0]   a_i,
    input  logic [B_WIDTH-1:0]   b_i,
    input  logic                 unsigned_a_i,
    input  logic                 unsigned_b_i,
    input  logic                 acc_en_i,
    input  logic                 acc_clr_i,
    input  logic [SHIFT_W-1:0]   shift_right_i,
    input  logic                 round_i,
    input  logic                 saturate_i,
    output logic                 valid_o,
    output logic [OUT_WIDTH-1:0] z_o,
    output logic                 overflow_o,
    output logic                 sat_o
);

    localparam int PROD_W = A_WIDTH + B_WIDTH + 2;

    // ---------------------------------------------------------------- checks
    if (ACC_WIDTH < min_acc_width(A_WIDTH, B_WIDTH)) begin : g_chk_acc
        $error("dsp_mac_pipe: ACC_WIDTH must be >= A_WIDTH+B_WIDTH+1");
    end
    if (OUT_WIDTH > ACC_WIDTH || OUT_WIDTH < 1) begin : g_chk_out
        $error("dsp_mac_pipe: OUT_WIDTH must be in 1..ACC_WIDTH");
    end
    if (PIPE_STAGES < 0 || PIPE_STAGES > PIPE_STAGES_MAX) begin : g_chk_pipe
        $error("dsp_mac_pipe: PIPE_STAGES must be in 0..2");
    end
    if (REGISTER_INPUTS < 0 ||
        mac_latency(REGISTER_INPUTS, PIPE_STAGES) > mac_latency(1, PIPE_STAGES)) begin : g_chk_reg
        $error("dsp_mac_pipe: REGISTER_INPUTS must be 0 or 1");
    end
    if (ACC_WIDTH + 1 > SAT_CALC_W) begin : g_chk_sat
        $error("dsp_mac_pipe: ACC_WIDTH too wide for saturation compare");
    end

    // ----------------------------------------------------------- input stage
    mac_ctrl_t          in_ctrl;
    mac_ctrl_t          s0_ctrl;
    logic [A_WIDTH-1:0] s0_a;
    logic [B_WIDTH-1:0] s0_b;
    logic               s0_ua;
    logic               s0_ub;

    assign in_ctrl = '{valid:    valid_i,
                       acc_en:   acc_en_i,
                       acc_clr:  acc_clr_i,
                       shift:    shift_right_i,
                       round:    round_i,
                       saturate: saturate_i};

    if (REGISTER_INPUTS != 0) begin : g_in_reg
        always_ff @(posedge clock_i or posedge reset_i) begin
            if (reset_i) begin
                s0_ctrl <= '0;
                s0_a    <= '0;
                s0_b    <= '0;
                s0_ua   <= 1'b0;
                s0_ub   <= 1'b0;
            end else begin
                s0_ctrl <= in_ctrl;
                s0_a    <= a_i;
                s0_b    <= b_i;
                s0_ua   <= unsigned_a_i;
                s0_ub   <= unsigned_b_i;
            end
        end
    end else begin : g_in_bypass
        assign s0_ctrl = in_ctrl;
        assign s0_a    = a_i;
        assign s0_b    = b_i;
        assign s0_ua   = unsigned_a_i;
        assign s0_ub   = unsigned_b_i;
    end

    // ------------------------------------------------------------ multiplier
    // One extra bit per operand lets both signed and unsigned values be
    // multiplied as signed numbers.
    logic signed [A_WIDTH:0]     a_ext;
    logic signed [B_WIDTH:0]     b_ext;
    logic signed [PROD_W-1:0]    prod;
    logic signed [ACC_WIDTH-1:0] prod_acc;

    assign a_ext    = {~s0_ua & s0_a[A_WIDTH-1], s0_a};
    assign b_ext    = {~s0_ub & s0_b[B_WIDTH-1], s0_b};
    assign prod     = PROD_W'(a_ext) * PROD_W'(b_ext);
    assign prod_acc = ACC_WIDTH'(prod);

    // --------------------------------------------------- product pipe stages
    logic signed [ACC_WIDTH-1:0] acc_p;
    mac_ctrl_t                   acc_c;

    if (PIPE_STAGES == 0) begin : g_no_pipe
        assign acc_p = prod_acc;
        assign acc_c = s0_ctrl;
    end else begin : g_pipe
        logic signed [ACC_WIDTH-1:0] pp_q [PIPE_STAGES];
        mac_ctrl_t                   pc_q [PIPE_STAGES];

        // NOTE: these stage arrays are plain flops, not RAM, so they take the
        // async reset; a stale valid bit must never survive reset.
        always_ff @(posedge clock_i or posedge reset_i) begin
            if (reset_i) begin
                for (int k = 0; k < PIPE_STAGES; k++) begin
                    pp_q[k] <= '0;
                    pc_q[k] <= '0;
                end
            end else begin
                pp_q[0] <= prod_acc;
                pc_q[0] <= s0_ctrl;
                for (int k = 1; k < PIPE_STAGES; k++) begin
                    pp_q[k] <= pp_q[k-1];
                    pc_q[k] <= pc_q[k-1];
                end
            end
        end

        assign acc_p = pp_q[PIPE_STAGES-1];
        assign acc_c = pc_q[PIPE_STAGES-1];
    end

    // ----------------------------------------------------- accumulator stage
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] acc_sum;
    logic                        add_ovf;
    logic                        acc_ovf_q;
    logic                        acc_valid_q;
    logic [SHIFT_W-1:0]          acc_shift_q;
    logic                        acc_round_q;
    logic                        acc_sat_q;

    assign acc_sum = acc_q + acc_p;
    // Signed overflow: like-signed operands producing an opposite-signed sum.
    assign add_ovf = (acc_q[ACC_WIDTH-1] == acc_p[ACC_WIDTH-1]) &&
                     (acc_sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);

    // NOTE: non-blocking assignments here mean acc_sum always sees the
    // pre-edge acc_q, giving single-cycle feedback with no ordering hazard.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            acc_q       <= '0;
            acc_ovf_q   <= 1'b0;
            acc_valid_q <= 1'b0;
            acc_shift_q <= '0;
            acc_round_q <= 1'b0;
            acc_sat_q   <= 1'b0;
        end else begin
            acc_valid_q <= acc_c.valid;
            acc_shift_q <= acc_c.shift;
            acc_round_q <= acc_c.round;
            acc_sat_q   <= acc_c.saturate;
            if (acc_c.valid) begin
                if (acc_c.acc_en && !acc_c.acc_clr) begin
                    acc_q     <= acc_sum;
                    acc_ovf_q <= acc_ovf_q | add_ovf;
                end else begin
                    acc_q     <= acc_p;
                    acc_ovf_q <= 1'b0;
                end
            end
        end
    end

    // ---------------------------------------------------------- output stage
    logic [OUT_WIDTH-1:0] rs_z;
    logic                 rs_sat;
    logic                 valid_q;
    logic [OUT_WIDTH-1:0] z_q;
    logic                 ovf_q;
    logic                 sat_q;

    dsp_mac_round_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_round_sat (
        .acc      (acc_q),
        .shift    (acc_shift_q),
        .round    (acc_round_q),
        .saturate (acc_sat_q),
        .z        (rs_z),
        .sat      (rs_sat)
    );

    // The overflow flag is re-registered here so it changes in the same cycle
    // as the result it belongs to.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
            z_q     <= '0;
            ovf_q   <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            valid_q <= acc_valid_q;
            if (acc_valid_q) begin
                z_q   <= rs_z;
                ovf_q <= acc_ovf_q;
                sat_q <= rs_sat;
            end
        end
    end

    assign valid_o    = valid_q;
    assign z_o        = z_q;
    assign overflow_o = ovf_q;
    assign sat_o      = sat_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
module tb_dsp_mac_pipe;

    localparam int ND   = 3;   // 0: defaults, 1: REGISTER_INPUTS=0, 2: PIPE_STAGES=2
    localparam int ACCW = 40;
    localparam int OW   = 38;
    localparam longint ACC_MAX = (longint'(1) << (ACCW - 1)) - 1;
    localparam longint ACC_MIN = -(longint'(1) << (ACCW - 1));
    localparam longint OUT_MAX = (longint'(1) << (OW - 1)) - 1;
    localparam longint OUT_MIN = -(longint'(1) << (OW - 1));

    typedef struct {
        int          edge_n;
        logic [37:0] z;
        logic        sat;
        logic        ovf;
    } res_t;

    logic        clock;
    logic        reset;
    logic        valid_in;
    logic [19:0] a;
    logic [17:0] b;
    logic        ua, ub, acc_en, acc_clr, round, saturate;
    logic [5:0]  shift;

    logic        vo  [ND];
    logic [37:0] zo  [ND];
    logic        ovo [ND];
    logic        so  [ND];

    int     lat [ND];
    res_t   exp_q [ND][$];
    res_t   got_q [ND][$];
    res_t   held  [ND];
    int     errors = 0;
    int     checks = 0;
    int     ecount = 0;
    longint m_acc  = 0;
    bit     m_ovf  = 0;

    dsp_mac_pipe #(.REGISTER_INPUTS(1), .PIPE_STAGES(0)) u_def (
        .clock_i(clock), .reset_i(reset), .valid_i(valid_in), .a_i(a), .b_i(b),
        .unsigned_a_i(ua), .unsigned_b_i(ub), .acc_en_i(acc_en), .acc_clr_i(acc_clr),
        .shift_right_i(shift), .round_i(round), .saturate_i(saturate),
        .valid_o(vo[0]), .z_o(zo[0]), .overflow_o(ovo[0]), .sat_o(so[0]));

    dsp_mac_pipe #(.REGISTER_INPUTS(0), .PIPE_STAGES(0)) u_noreg (
        .clock_i(clock), .reset_i(reset), .valid_i(valid_in), .a_i(a), .b_i(b),
        .unsigned_a_i(ua), .unsigned_b_i(ub), .acc_en_i(acc_en), .acc_clr_i(acc_clr),
        .shift_right_i(shift), .round_i(round), .saturate_i(saturate),
        .valid_o(vo[1]), .z_o(zo[1]), .overflow_o(ovo[1]), .sat_o(so[1]));

    dsp_mac_pipe #(.REGISTER_INPUTS(1), .PIPE_STAGES(2)) u_pipe2 (
        .clock_i(clock), .reset_i(reset), .valid_i(valid_in), .a_i(a), .b_i(b),
        .unsigned_a_i(ua), .unsigned_b_i(ub), .acc_en_i(acc_en), .acc_clr_i(acc_clr),
        .shift_right_i(shift), .round_i(round), .saturate_i(saturate),
        .valid_o(vo[2]), .z_o(zo[2]), .overflow_o(ovo[2]), .sat_o(so[2]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Sign-extend the low w bits of x.
    function automatic longint wrap(input longint x, input int w);
        longint m;
        m = x & ((longint'(1) << w) - 1);
        if (m[w-1]) m = m - (longint'(1) << w);
        return m;
    endfunction

    // Scoreboard: 1 time unit after each edge, every DUT must either present
    // the next expected result (on its due edge) or hold its previous outputs.
    always @(posedge clock) begin
        res_t e;
        res_t g;
        #1;
        ecount++;
        if (!reset) begin
            for (int i = 0; i < ND; i++) begin
                if (vo[i]) begin
                    g.edge_n = ecount; g.z = zo[i]; g.sat = so[i]; g.ovf = ovo[i];
                    got_q[i].push_back(g);
                end
                checks++;
                if (exp_q[i].size() != 0 && exp_q[i][0].edge_n == ecount) begin
                    e = exp_q[i].pop_front();
                    held[i] = e;
                    if (vo[i] !== 1'b1 || zo[i] !== e.z || so[i] !== e.sat || ovo[i] !== e.ovf) begin
                        errors++;
                        $display("FAIL result dut%0d edge %0d: got v=%b z=%h sat=%b ovf=%b, want v=1 z=%h sat=%b ovf=%b",
                                 i, ecount, vo[i], zo[i], so[i], ovo[i], e.z, e.sat, e.ovf);
                    end
                end else begin
                    if (vo[i] !== 1'b0 || zo[i] !== held[i].z || so[i] !== held[i].sat || ovo[i] !== held[i].ovf) begin
                        errors++;
                        $display("FAIL hold dut%0d edge %0d: got v=%b z=%h sat=%b ovf=%b, want v=0 z=%h sat=%b ovf=%b",
                                 i, ecount, vo[i], zo[i], so[i], ovo[i], held[i].z, held[i].sat, held[i].ovf);
                    end
                end
            end
        end
    end

    // Drive one cycle of inputs; a valid sample is run through the reference
    // model and its result queued for each DUT at its own latency.
    task automatic drive(input logic v, input logic [19:0] av, input logic [17:0] bv,
                         input logic uav, input logic ubv, input logic en, input logic clr,
                         input logic [5:0] sh, input logic rn, input logic st);
        longint x, y, p, sum, r, q;
        res_t   e;
        valid_in = v; a = av; b = bv; ua = uav; ub = ubv;
        acc_en = en; acc_clr = clr; shift = sh; round = rn; saturate = st;
        if (v) begin
            x = uav ? longint'(av) : longint'($signed(av));
            y = ubv ? longint'(bv) : longint'($signed(bv));
            p = x * y;
            if (en && !clr) begin
                sum = m_acc + p;
                if (sum > ACC_MAX || sum < ACC_MIN) m_ovf = 1'b1;
                m_acc = wrap(sum, ACCW);
            end else begin
                m_acc = p;
                m_ovf = 1'b0;
            end
            r = m_acc;
            if (rn && sh != 0) r = r + (longint'(1) << (sh - 6'd1));
            r = wrap(r, ACCW + 1);
            q = r >>> sh;
            e.sat = 1'b0;
            if (st && q > OUT_MAX) begin
                q = OUT_MAX; e.sat = 1'b1;
            end else if (st && q < OUT_MIN) begin
                q = OUT_MIN; e.sat = 1'b1;
            end
            e.z   = 38'(q);
            e.ovf = m_ovf;
            for (int i = 0; i < ND; i++) begin
                e.edge_n = ecount + lat[i];
                exp_q[i].push_back(e);
            end
        end
        @(posedge clock);
        #2;
    endtask

    task automatic idle();
        drive(1'b0, 20'($urandom), 18'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 6'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic drain();
        int  n;
        bit  busy;
        n    = 0;
        busy = 1'b1;
        while (busy && n < 30) begin
            idle();
            n++;
            busy = 1'b0;
            for (int i = 0; i < ND; i++) if (exp_q[i].size() != 0) busy = 1'b1;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL drain timeout: results still outstanding after %0d cycles", n);
        end
    endtask

    task automatic clear_got();
        for (int i = 0; i < ND; i++) got_q[i].delete();
    endtask

    task automatic test_reset();
        for (int i = 0; i < ND; i++) begin
            checks++;
            if (vo[i] !== 1'b0 || zo[i] !== '0 || ovo[i] !== 1'b0 || so[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset dut%0d: got v=%b z=%h ovf=%b sat=%b, want all 0",
                         i, vo[i], zo[i], ovo[i], so[i]);
            end
        end
    endtask

    task automatic test_signed_mul();
        int start;
        drain();
        clear_got();
        start = ecount;
        drive(1'b1, 20'hFFFFD, 18'd7, 0, 0, 0, 0, 6'd0, 0, 0);
        repeat (8) idle();
        for (int i = 0; i < ND; i++) begin
            checks++;
            if (got_q[i].size() != 1) begin
                errors++;
                $display("FAIL signed_mul pulses dut%0d: got %0d, want 1", i, got_q[i].size());
            end else if (got_q[i][0].edge_n - start != lat[i] || got_q[i][0].z !== 38'h3F_FFFF_FFEB) begin
                errors++;
                $display("FAIL signed_mul dut%0d: got lat=%0d z=%h, want lat=%0d z=3fffffffeb",
                         i, got_q[i][0].edge_n - start, got_q[i][0].z, lat[i]);
            end
        end
    endtask

    task automatic test_unsigned_mul();
        drain();
        clear_got();
        drive(1'b1, 20'hFFFFF, 18'h3FFFF, 1, 1, 0, 0, 6'd0, 0, 0);
        drive(1'b1, 20'hFFFFF, 18'h3FFFF, 1, 1, 0, 0, 6'd0, 0, 1);
        drain();
        for (int i = 0; i < ND; i++) begin
            checks++;
            if (got_q[i].size() != 2 ||
                got_q[i][0].z !== 38'h3F_FFEC_0001 || got_q[i][0].sat !== 1'b0 ||
                got_q[i][1].z !== 38'h1F_FFFF_FFFF || got_q[i][1].sat !== 1'b1) begin
                errors++;
                $display("FAIL unsigned_mul dut%0d: got %0d results, first z=%h sat=%b, want 3fffec0001/0 then 1fffffffff/1",
                         i, got_q[i].size(), zo[i], so[i]);
            end
        end
    endtask

    task automatic test_accumulate(input int gap);
        logic [37:0] want;
        drain();
        clear_got();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 20'd1000, 18'd1000, 0, 0, 1, (k == 0), 6'd0, 0, 0);
            repeat (gap) idle();
        end
        drain();
        for (int i = 0; i < ND; i++) begin
            checks++;
            if (got_q[i].size() != 4) begin
                errors++;
                $display("FAIL accumulate gap=%0d dut%0d count: got %0d, want 4", gap, i, got_q[i].size());
            end else begin
                for (int k = 0; k < 4; k++) begin
                    want = 38'((k + 1) * 1000000);
                    checks++;
                    if (got_q[i][k].z !== want ||
                        (k > 0 && got_q[i][k].edge_n - got_q[i][k-1].edge_n != gap + 1)) begin
                        errors++;
                        $display("FAIL accumulate gap=%0d dut%0d #%0d: got z=%h, want z=%h spaced %0d",
                                 gap, i, k, got_q[i][k].z, want, gap + 1);
                    end
                end
            end
        end
    endtask

    task automatic test_rounding();
        drain();
        clear_got();
        drive(1'b1, 20'd10, 18'd1, 0, 0, 0, 0, 6'd2, 1, 0);
        drive(1'b1, 20'd10, 18'd1, 0, 0, 0, 0, 6'd2, 0, 0);
        drive(1'b1, 20'hFFFF6, 18'd1, 0, 0, 0, 0, 6'd2, 1, 0);
        drain();
        checks++;
        if (got_q[0].size() != 3 || got_q[0][0].z !== 38'd3 || got_q[0][1].z !== 38'd2 ||
            got_q[0][2].z !== 38'h3F_FFFF_FFFE) begin
            errors++;
            $display("FAIL rounding: got %0d results, last z=%h, want 3, 2, -2", got_q[0].size(), zo[0]);
        end
    endtask

    task automatic test_overflow();
        drain();
        clear_got();
        for (int k = 0; k < 10; k++) drive(1'b1, 20'h80000, 18'h20000, 0, 0, 1, (k == 0), 6'd0, 0, 0);
        drive(1'b1, 20'h80000, 18'h20000, 0, 0, 1, 1, 6'd0, 0, 0);
        drain();
        for (int i = 0; i < ND; i++) begin
            checks++;
            if (got_q[i].size() != 11 || got_q[i][6].ovf !== 1'b0 || got_q[i][7].ovf !== 1'b1 ||
                got_q[i][7].z !== 38'd0 || got_q[i][9].ovf !== 1'b1 || got_q[i][10].ovf !== 1'b0) begin
                errors++;
                $display("FAIL overflow dut%0d: got %0d results, ovf now %b, want rise on 8th, hold, clear on clr",
                         i, got_q[i].size(), ovo[i]);
            end
        end
    endtask

    task automatic test_shift_bounds();
        drain();
        clear_got();
        drive(1'b1, 20'd5, 18'd1, 0, 0, 0, 0, 6'd0, 1, 0);
        drive(1'b1, 20'hFFFFB, 18'd1, 0, 0, 0, 0, 6'd40, 0, 0);
        drive(1'b1, 20'd7, 18'd1, 0, 0, 0, 0, 6'd63, 0, 0);
        drain();
        checks++;
        if (got_q[0].size() != 3 || got_q[0][0].z !== 38'd5 ||
            got_q[0][1].z !== 38'h3F_FFFF_FFFF || got_q[0][2].z !== 38'd0) begin
            errors++;
            $display("FAIL shift_bounds: got %0d results, last z=%h, want 5, -1, 0", got_q[0].size(), zo[0]);
        end
    endtask

    task automatic test_reset_mid_run();
        int start;
        drain();
        for (int k = 0; k < 3; k++) drive(1'b1, 20'd1000, 18'd1000, 0, 0, 1, (k == 0), 6'd0, 0, 0);
        reset = 1'b1;
        for (int i = 0; i < ND; i++) begin
            exp_q[i].delete();
            held[i].z = '0; held[i].sat = 1'b0; held[i].ovf = 1'b0;
        end
        m_acc = 0;
        m_ovf = 1'b0;
        #1;
        test_reset();
        @(posedge clock);
        #2;
        reset = 1'b0;
        clear_got();
        start = ecount;
        drive(1'b1, 20'd1000, 18'd1000, 0, 0, 1, 0, 6'd0, 0, 0);
        repeat (8) idle();
        for (int i = 0; i < ND; i++) begin
            checks++;
            if (got_q[i].size() != 1 || got_q[i][0].edge_n - start != lat[i] || got_q[i][0].z !== 38'd1000000) begin
                errors++;
                $display("FAIL reset_mid_run dut%0d: got %0d results z=%h, want one at lat %0d z=f4240",
                         i, got_q[i].size(), zo[i], lat[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [19:0] av;
        logic [17:0] bv;
        logic [5:0]  sh;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0:       av = 20'h80000;
                1:       av = 20'h7FFFF;
                default: av = 20'($urandom);
            endcase
            bv = ($urandom_range(0, 3) == 0) ? 18'h20000 : 18'($urandom);
            sh = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 8));
            drive(($urandom_range(0, 9) < 7), av, bv, 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0),
                  sh, 1'($urandom), 1'($urandom));
        end
        drain();
    endtask

    initial begin
        lat[0] = 3; lat[1] = 2; lat[2] = 5;
        for (int i = 0; i < ND; i++) begin
            held[i].edge_n = 0; held[i].z = '0; held[i].sat = 1'b0; held[i].ovf = 1'b0;
        end
        reset = 1'b1;
        valid_in = 0; a = '0; b = '0; ua = 0; ub = 0;
        acc_en = 0; acc_clr = 0; shift = '0; round = 0; saturate = 0;
        repeat (2) @(posedge clock);
        #2;
        test_reset();
        reset = 1'b0;
        @(posedge clock);
        #2;
        test_signed_mul();
        test_unsigned_mul();
        test_accumulate(0);
        test_accumulate(2);
        test_rounding();
        test_overflow();
        test_shift_bounds();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
